// File: rtl/mem_stage.sv
// Memory-access stage of the 8-bit RISC-V pipeline: EX/MEM register,
// data memory, branch resolution and the MEM/WB register with the
// write-back mux that feeds the register file.
module mem_stage #(
    parameter int PC_SIZE    = 10,
    parameter int DMEM_DEPTH = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic [PC_SIZE-1:0] PC_jump,
    input  logic               zero,
    input  logic [7:0]         ALU_result,
    input  logic [7:0]         write_data,
    input  logic [4:0]         rd_in,
    input  logic               branch_in,
    input  logic               mem_read_in,
    input  logic               mem_to_reg_in,
    input  logic               mem_write_in,
    input  logic               reg_write_in,
    output logic               pc_src,
    output logic [PC_SIZE-1:0] branch_target,
    output logic [7:0]         mem_read_data,
    output logic [7:0]         wb_alu_result,
    output logic [7:0]         wb_data,
    output logic [4:0]         rd_out,
    output logic               reg_write_out,
    output logic               mem_to_reg_out
);

    localparam int         ADDR_W      = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
    localparam logic [8:0] DEPTH_LIMIT = 9'(DMEM_DEPTH);

    logic [PC_SIZE-1:0] ex_pc_jump;
    logic               ex_zero;
    logic [7:0]         ex_alu_result;
    logic [7:0]         ex_write_data;
    logic [4:0]         ex_rd;
    logic               ex_branch;
    logic               ex_mem_read;
    logic               ex_mem_to_reg;
    logic               ex_mem_write;
    logic               ex_reg_write;

    logic [7:0]         dmem [DMEM_DEPTH];
    logic               addr_in_range;
    logic [ADDR_W-1:0]  mem_index;
    logic [7:0]         read_data;

    // EX/MEM register: reset and flush insert a bubble, stall holds the entry
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ex_pc_jump    <= '0;
            ex_zero       <= 1'b0;
            ex_alu_result <= '0;
            ex_write_data <= '0;
            ex_rd         <= '0;
            ex_branch     <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
        end else if (!stall) begin
            ex_pc_jump    <= PC_jump;
            ex_zero       <= zero;
            ex_alu_result <= ALU_result;
            ex_write_data <= write_data;
            ex_rd         <= rd_in;
            ex_branch     <= branch_in;
            ex_mem_read   <= mem_read_in;
            ex_mem_to_reg <= mem_to_reg_in;
            ex_mem_write  <= mem_write_in;
            ex_reg_write  <= reg_write_in;
        end
    end

    assign addr_in_range = ({1'b0, ex_alu_result} < DEPTH_LIMIT);
    assign mem_index     = ex_alu_result[ADDR_W-1:0];

    // Branch is resolved from the entry currently held in EX/MEM
    assign pc_src        = ex_branch & ex_zero;
    assign branch_target = ex_pc_jump;

    // Load path: out-of-range addresses and non-load entries read as zero
    always_comb begin
        read_data = '0;
        if (ex_mem_read && addr_in_range) begin
            read_data = dmem[mem_index];
        end
    end

    // Store commits only when its entry advances, so a stalled store writes once
    always_ff @(posedge clk) begin
        if (!reset && !stall && ex_mem_write && addr_in_range) begin
            dmem[mem_index] <= ex_write_data;
        end
    end

    // MEM/WB register: reset and stall both push a bubble toward write-back
    always_ff @(posedge clk) begin
        if (reset || stall) begin
            mem_read_data  <= '0;
            wb_alu_result  <= '0;
            rd_out         <= '0;
            reg_write_out  <= 1'b0;
            mem_to_reg_out <= 1'b0;
        end else begin
            mem_read_data  <= read_data;
            wb_alu_result  <= ex_alu_result;
            rd_out         <= ex_rd;
            reg_write_out  <= ex_reg_write;
            mem_to_reg_out <= ex_mem_to_reg;
        end
    end

    assign wb_data = mem_to_reg_out ? mem_read_data : wb_alu_result;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model.
module tb_mem_stage;

    localparam int PC_SIZE = 10;
    localparam int DEPTH   = 128;

    typedef struct packed {
        logic [9:0] pc_jump;
        logic       zero;
        logic [7:0] alu;
        logic [7:0] wdata;
        logic [4:0] rd;
        logic       branch;
        logic       mread;
        logic       m2r;
        logic       mwrite;
        logic       regw;
    } instr_t;

    typedef struct packed {
        logic [7:0] rdata;
        logic [7:0] alu;
        logic [4:0] rd;
        logic       regw;
        logic       m2r;
    } wb_t;

    logic               clk;
    logic               reset;
    logic               stall;
    logic               flush;
    logic [PC_SIZE-1:0] PC_jump;
    logic               zero;
    logic [7:0]         ALU_result;
    logic [7:0]         write_data;
    logic [4:0]         rd_in;
    logic               branch_in;
    logic               mem_read_in;
    logic               mem_to_reg_in;
    logic               mem_write_in;
    logic               reg_write_in;
    logic               pc_src;
    logic [PC_SIZE-1:0] branch_target;
    logic [7:0]         mem_read_data;
    logic [7:0]         wb_alu_result;
    logic [7:0]         wb_data;
    logic [4:0]         rd_out;
    logic               reg_write_out;
    logic               mem_to_reg_out;

    int assertCount = 0;
    int failCount   = 0;

    // Reference state: the instruction waiting in the memory stage, the
    // result heading to write-back, and the architectural memory contents
    instr_t     refSlot;
    wb_t        refWb;
    logic [7:0] refMem [256];

    mem_stage #(.PC_SIZE(PC_SIZE), .DMEM_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .PC_jump(PC_jump), .zero(zero), .ALU_result(ALU_result),
        .write_data(write_data), .rd_in(rd_in), .branch_in(branch_in),
        .mem_read_in(mem_read_in), .mem_to_reg_in(mem_to_reg_in),
        .mem_write_in(mem_write_in), .reg_write_in(reg_write_in),
        .pc_src(pc_src), .branch_target(branch_target),
        .mem_read_data(mem_read_data), .wb_alu_result(wb_alu_result),
        .wb_data(wb_data), .rd_out(rd_out), .reg_write_out(reg_write_out),
        .mem_to_reg_out(mem_to_reg_out)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value with its expected value and log mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic instr_t nopOp();
        return '0;
    endfunction

    function automatic instr_t storeOp(input logic [7:0] addr, input logic [7:0] data);
        instr_t ins = '0;
        ins.alu    = addr;
        ins.wdata  = data;
        ins.mwrite = 1'b1;
        return ins;
    endfunction

    function automatic instr_t loadOp(input logic [7:0] addr, input logic [4:0] rd);
        instr_t ins = '0;
        ins.alu   = addr;
        ins.rd    = rd;
        ins.mread = 1'b1;
        ins.m2r   = 1'b1;
        ins.regw  = 1'b1;
        return ins;
    endfunction

    // Advance the reference by one clock edge using the stage's transfer rules
    task automatic modelStep(input instr_t ins, input logic st, input logic fl, input logic rs);
        int addr;
        addr = int'(refSlot.alu);
        if (rs) begin
            refSlot = '0;
            refWb   = '0;
        end else begin
            if (st) begin
                refWb = '0;
            end else begin
                refWb.rdata = (refSlot.mread && addr < DEPTH) ? refMem[addr] : 8'h00;
                refWb.alu   = refSlot.alu;
                refWb.rd    = refSlot.rd;
                refWb.regw  = refSlot.regw;
                refWb.m2r   = refSlot.m2r;
                if (refSlot.mwrite && addr < DEPTH) refMem[addr] = refSlot.wdata;
            end
            if (fl)       refSlot = '0;
            else if (!st) refSlot = ins;
        end
    endtask

    // Drive one cycle of inputs, clock it, then compare every output
    task automatic applyStimulus(input instr_t ins, input logic st, input logic fl, input logic rs);
        PC_jump       = ins.pc_jump;
        zero          = ins.zero;
        ALU_result    = ins.alu;
        write_data    = ins.wdata;
        rd_in         = ins.rd;
        branch_in     = ins.branch;
        mem_read_in   = ins.mread;
        mem_to_reg_in = ins.m2r;
        mem_write_in  = ins.mwrite;
        reg_write_in  = ins.regw;
        stall         = st;
        flush         = fl;
        reset         = rs;
        @(posedge clk);
        modelStep(ins, st, fl, rs);
        @(negedge clk);
        checkOutput("pc_src",         32'(pc_src),         32'(refSlot.branch & refSlot.zero));
        checkOutput("branch_target",  32'(branch_target),  32'(refSlot.pc_jump));
        checkOutput("mem_read_data",  32'(mem_read_data),  32'(refWb.rdata));
        checkOutput("wb_alu_result",  32'(wb_alu_result),  32'(refWb.alu));
        checkOutput("wb_data",        32'(wb_data),        32'(refWb.m2r ? refWb.rdata : refWb.alu));
        checkOutput("rd_out",         32'(rd_out),         32'(refWb.rd));
        checkOutput("reg_write_out",  32'(reg_write_out),  32'(refWb.regw));
        checkOutput("mem_to_reg_out", 32'(mem_to_reg_out), 32'(refWb.m2r));
    endtask

    // Directed scenarios, then randomized traffic, then the summary
    initial begin
        instr_t ins;
        logic   st, fl, rs;
        refSlot = '0;
        refWb   = '0;
        for (int i = 0; i < 256; i++) refMem[i] = 8'h00;

        applyStimulus(nopOp(), 1'b0, 1'b0, 1'b1);
        checkOutput("reset_wb_data", 32'(wb_data), 32'h0);
        checkOutput("reset_regw",    32'(reg_write_out), 32'h0);

        // Give every implemented location a defined value
        for (int i = 0; i < DEPTH; i++) applyStimulus(storeOp(8'(i), 8'h00), 1'b0, 1'b0, 1'b0);

        // Store then load
        applyStimulus(storeOp(8'h10, 8'hA5), 1'b0, 1'b0, 1'b0);
        applyStimulus(loadOp(8'h10, 5'd5), 1'b0, 1'b0, 1'b0);
        applyStimulus(nopOp(), 1'b0, 1'b0, 1'b0);
        checkOutput("tp1_wb_data", 32'(wb_data), 32'hA5);
        checkOutput("tp1_rd_out",  32'(rd_out), 32'd5);
        checkOutput("tp1_regw",    32'(reg_write_out), 32'h1);

        // Branch taken, then not taken
        ins = '0; ins.branch = 1'b1; ins.zero = 1'b1; ins.pc_jump = 10'h123;
        applyStimulus(ins, 1'b0, 1'b0, 1'b0);
        checkOutput("tp2_taken",  32'(pc_src), 32'h1);
        checkOutput("tp2_target", 32'(branch_target), 32'h123);
        ins.zero = 1'b0;
        applyStimulus(ins, 1'b0, 1'b0, 1'b0);
        checkOutput("tp2_not_taken", 32'(pc_src), 32'h0);

        // Flushed store leaves memory untouched
        applyStimulus(storeOp(8'h20, 8'h33), 1'b0, 1'b0, 1'b0);
        applyStimulus(storeOp(8'h20, 8'h77), 1'b0, 1'b1, 1'b0);
        checkOutput("tp3_pc_src", 32'(pc_src), 32'h0);
        applyStimulus(loadOp(8'h20, 5'd3), 1'b0, 1'b0, 1'b0);
        checkOutput("tp3_bubble_regw", 32'(reg_write_out), 32'h0);
        applyStimulus(nopOp(), 1'b0, 1'b0, 1'b0);
        checkOutput("tp3_mem_kept", 32'(wb_data), 32'h33);

        // Stall holds the ALU op and releases exactly one write-back
        ins = '0; ins.alu = 8'h3C; ins.rd = 5'd7; ins.regw = 1'b1;
        applyStimulus(ins, 1'b0, 1'b0, 1'b0);
        applyStimulus(nopOp(), 1'b1, 1'b0, 1'b0);
        checkOutput("tp4_stall1_regw", 32'(reg_write_out), 32'h0);
        applyStimulus(nopOp(), 1'b1, 1'b0, 1'b0);
        checkOutput("tp4_stall2_regw", 32'(reg_write_out), 32'h0);
        applyStimulus(nopOp(), 1'b0, 1'b0, 1'b0);
        checkOutput("tp4_wb_data", 32'(wb_data), 32'h3C);
        checkOutput("tp4_rd_out",  32'(rd_out), 32'd7);
        checkOutput("tp4_regw",    32'(reg_write_out), 32'h1);
        applyStimulus(nopOp(), 1'b0, 1'b0, 1'b0);
        checkOutput("tp4_once", 32'(reg_write_out), 32'h0);

        // Out-of-range store is dropped and does not alias in-range memory
        applyStimulus(storeOp(8'h90, 8'h55), 1'b0, 1'b0, 1'b0);
        applyStimulus(loadOp(8'h90, 5'd9), 1'b0, 1'b0, 1'b0);
        applyStimulus(loadOp(8'h10, 5'd9), 1'b0, 1'b0, 1'b0);
        checkOutput("tp5_oor_read", 32'(wb_data), 32'h00);
        applyStimulus(nopOp(), 1'b0, 1'b0, 1'b0);
        checkOutput("tp5_no_alias", 32'(wb_data), 32'hA5);

        // Stalled store followed by reset must never reach memory
        applyStimulus(storeOp(8'h30, 8'h99), 1'b0, 1'b0, 1'b0);
        applyStimulus(nopOp(), 1'b1, 1'b0, 1'b0);
        applyStimulus(nopOp(), 1'b0, 1'b0, 1'b1);
        applyStimulus(loadOp(8'h30, 5'd1), 1'b0, 1'b0, 1'b0);
        applyStimulus(nopOp(), 1'b0, 1'b0, 1'b0);
        checkOutput("tp4_stalled_store_dropped", 32'(wb_data), 32'h00);

        // Reset with a store in flight
        applyStimulus(storeOp(8'h08, 8'hEE), 1'b0, 1'b0, 1'b0);
        applyStimulus(nopOp(), 1'b0, 1'b0, 1'b1);
        checkOutput("tp6_pc_src",  32'(pc_src), 32'h0);
        checkOutput("tp6_target",  32'(branch_target), 32'h0);
        checkOutput("tp6_wb_data", 32'(wb_data), 32'h0);
        checkOutput("tp6_rd_out",  32'(rd_out), 32'h0);
        checkOutput("tp6_regw",    32'(reg_write_out), 32'h0);
        applyStimulus(loadOp(8'h08, 5'd2), 1'b0, 1'b0, 1'b0);
        applyStimulus(nopOp(), 1'b0, 1'b0, 1'b0);
        checkOutput("tp6_mem_kept", 32'(wb_data), 32'h00);

        // Random traffic concentrated on a few addresses to provoke hazards
        for (int n = 0; n < 600; n++) begin
            ins.pc_jump = 10'($urandom);
            ins.zero    = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       ins.alu = 8'($urandom);
                1:       ins.alu = 8'h78 + 8'($urandom_range(0, 15));
                default: ins.alu = 8'h10 + 8'($urandom_range(0, 7));
            endcase
            ins.wdata  = 8'($urandom);
            ins.rd     = 5'($urandom);
            ins.branch = 1'($urandom);
            ins.mread  = 1'($urandom);
            ins.m2r    = 1'($urandom);
            ins.mwrite = 1'($urandom);
            ins.regw   = 1'($urandom);
            st = ($urandom_range(0, 99) < 15);
            fl = ($urandom_range(0, 99) < 10);
            rs = ($urandom_range(0, 99) < 2);
            applyStimulus(ins, st, fl, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
